// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The slave side is the unit itself; the master issues operations and HI/LO moves.
interface muldiv_unit_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        wr_hi;
   logic        wr_lo;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, A, B, wr_hi, wr_lo, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, A, B, wr_hi, wr_lo, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// 32-cycle iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Signed operations run on magnitudes; signs are fixed up when the result commits.
module muldiv_unit (
   input  logic         clk,
   input  logic         rst,
   muldiv_unit_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        is_div_q, is_div_d;
   logic        neg_res_q, neg_res_d;
   logic        neg_rem_q, neg_rem_d;
   logic        div_zero_q, div_zero_d;
   logic [31:0] a_raw_q, a_raw_d;
   logic [31:0] opnd_q, opnd_d;
   logic [31:0] work_hi_q, work_hi_d;
   logic [31:0] work_lo_q, work_lo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;

   logic        is_signed, a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic        div_ge;
   logic [31:0] div_trial;
   logic [63:0] prod;
   logic [31:0] quo, rem;

   // Operand conditioning and one iteration step of each datapath
   always_comb begin
      is_signed = ~bus.op[0];
      a_neg     = is_signed & bus.A[31];
      b_neg     = is_signed & bus.B[31];
      a_mag     = a_neg ? (~bus.A + 32'd1) : bus.A;
      b_mag     = b_neg ? (~bus.B + 32'd1) : bus.B;
      mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
      div_shift = {work_hi_q, work_lo_q[31]};
      div_ge    = (div_shift >= {1'b0, opnd_q});
      div_trial = div_shift[31:0] - opnd_q;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_div_d   = is_div_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      div_zero_d = div_zero_q;
      a_raw_d    = a_raw_q;
      opnd_d     = opnd_q;
      work_hi_d  = work_hi_q;
      work_lo_d  = work_lo_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      prod       = 64'd0;
      quo        = 32'd0;
      rem        = 32'd0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d    = RUN;
               cnt_d      = 6'd0;
               is_div_d   = bus.op[1];
               neg_res_d  = a_neg ^ b_neg;
               neg_rem_d  = a_neg;
               div_zero_d = (bus.B == 32'd0);
               a_raw_d    = bus.A;
               work_hi_d  = 32'd0;
               work_lo_d  = bus.op[1] ? a_mag : b_mag;
               opnd_d     = bus.op[1] ? b_mag : a_mag;
            end else begin
               if (bus.wr_hi) hi_d = bus.wdata;
               if (bus.wr_lo) lo_d = bus.wdata;
            end
         end
         RUN: begin
            cnt_d = cnt_q + 6'd1;
            if (is_div_q) begin
               work_hi_d = div_ge ? div_trial : div_shift[31:0];
               work_lo_d = {work_lo_q[30:0], div_ge};
            end else begin
               work_hi_d = mul_sum[32:1];
               work_lo_d = {mul_sum[0], work_lo_q[31:1]};
            end
            // The last iteration and the commit share the same edge
            if (cnt_q == 6'd31) begin
               state_d = IDLE;
               cnt_d   = 6'd0;
               done_d  = 1'b1;
               if (is_div_q) begin
                  quo = neg_res_q ? (~work_lo_d + 32'd1) : work_lo_d;
                  rem = neg_rem_q ? (~work_hi_d + 32'd1) : work_hi_d;
                  if (div_zero_q) begin
                     lo_d = 32'hFFFF_FFFF;
                     hi_d = a_raw_q;
                  end else begin
                     lo_d = quo;
                     hi_d = rem;
                  end
               end else begin
                  prod = {work_hi_d, work_lo_d};
                  if (neg_res_q) prod = ~prod + 64'd1;
                  hi_d = prod[63:32];
                  lo_d = prod[31:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= 6'd0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         a_raw_q    <= 32'd0;
         opnd_q     <= 32'd0;
         work_hi_q  <= 32'd0;
         work_lo_q  <= 32'd0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_div_q   <= is_div_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         div_zero_q <= div_zero_d;
         a_raw_q    <= a_raw_d;
         opnd_q     <= opnd_d;
         work_hi_q  <= work_hi_d;
         work_lo_q  <= work_lo_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
      end
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, HI/LO move and abort sequences,
// and random operations checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   muldiv_unit_if bus_if ();

   muldiv_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs [10];

   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sp;
      logic [63:0]        up;
      logic signed [31:0] sa, sb, sq, sr;
      sa = a;
      sb = b;
      case (op)
         2'b00: begin
            sp = 64'(sa) * 64'(sb);
            return sp;
         end
         2'b01: begin
            up = {32'd0, a} * {32'd0, b};
            return up;
         end
         2'b10: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sq = sa / sb;
            sr = sa % sb;
            return {sr, sq};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Issues one operation at the next edge and waits (bounded) for its done pulse.
   // inj>0 re-drives start and MTHI for one cycle at that cycle of the run.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic wr, input int inj,
                        output logic [31:0] r_hi, output logic [31:0] r_lo);
      logic [31:0] hold_hi, hold_lo;
      int lat;
      @(negedge clk);
      hold_hi         = bus_if.hi;
      hold_lo         = bus_if.lo;
      bus_if.start    = 1'b1;
      bus_if.op       = op;
      bus_if.A        = a;
      bus_if.B        = b;
      bus_if.wr_hi    = wr;
      bus_if.wr_lo    = wr;
      bus_if.wdata    = 32'hA5A5_5A5A;
      @(posedge clk);
      #1;
      bus_if.start    = 1'b0;
      bus_if.wr_hi    = 1'b0;
      bus_if.wr_lo    = 1'b0;
      check("busy_after_accept", 64'(bus_if.busy), 64'd1);
      check("done_low_after_accept", 64'(bus_if.done), 64'd0);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (bus_if.done) begin
            lat = k;
            break;
         end
         if (k == 16) begin
            check("busy_mid_run", 64'(bus_if.busy), 64'd1);
            check("hold_hi", 64'(bus_if.hi), 64'(hold_hi));
            check("hold_lo", 64'(bus_if.lo), 64'(hold_lo));
         end
         if (inj != 0 && k == inj) begin
            bus_if.start = 1'b1;
            bus_if.op    = 2'b10;
            bus_if.A     = 32'h0000_0009;
            bus_if.B     = 32'h0000_0001;
            bus_if.wr_hi = 1'b1;
            bus_if.wdata = 32'hDEAD_BEEF;
         end
         if (inj != 0 && k == inj + 1) begin
            bus_if.start = 1'b0;
            bus_if.wr_hi = 1'b0;
         end
      end
      check("latency", 64'(lat), 64'd32);
      check("busy_at_done", 64'(bus_if.busy), 64'd0);
      r_hi = bus_if.hi;
      r_lo = bus_if.lo;
      $display("op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", op, a, b, r_hi, r_lo, lat);
   endtask

   initial begin
      logic [31:0] r_hi, r_lo;
      logic [63:0] exp;
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      logic        seen_done;
      checks = 0;
      errors = 0;

      vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
      vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[5] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
      vecs[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[7] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
      vecs[8] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
      vecs[9] = '{2'b00, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0000};

      rst          = 1'b0;
      bus_if.start = 1'b0;
      bus_if.op    = 2'b00;
      bus_if.A     = 32'd0;
      bus_if.B     = 32'd0;
      bus_if.wr_hi = 1'b0;
      bus_if.wr_lo = 1'b0;
      bus_if.wdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 64'(bus_if.busy), 64'd0);
      check("reset_done", 64'(bus_if.done), 64'd0);
      check("reset_hi", 64'(bus_if.hi), 64'd0);
      check("reset_lo", 64'(bus_if.lo), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // MTLO while idle, then a multiply with a stray start and MTHI mid-run
      @(negedge clk);
      bus_if.wr_lo = 1'b1;
      bus_if.wdata = 32'h1234_5678;
      @(posedge clk);
      #1;
      bus_if.wr_lo = 1'b0;
      check("mtlo_lo", 64'(bus_if.lo), 64'h1234_5678);
      check("mtlo_hi_untouched", 64'(bus_if.hi), 64'd0);
      do_op(2'b01, 32'd6, 32'd7, 1'b0, 5, r_hi, r_lo);
      check("busy_start_ignored_hi", 64'(r_hi), 64'd0);
      check("busy_start_ignored_lo", 64'(r_lo), 64'h2A);

      // MTHI+MTLO together, then start with MTHI/MTLO in the same cycle
      @(negedge clk);
      bus_if.wr_hi = 1'b1;
      bus_if.wr_lo = 1'b1;
      bus_if.wdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      bus_if.wr_hi = 1'b0;
      bus_if.wr_lo = 1'b0;
      check("mt_both_hi", 64'(bus_if.hi), 64'hCAFE_F00D);
      check("mt_both_lo", 64'(bus_if.lo), 64'hCAFE_F00D);
      do_op(2'b00, 32'd3, 32'd5, 1'b1, 0, r_hi, r_lo);
      check("start_priority_hi", 64'(r_hi), 64'd0);
      check("start_priority_lo", 64'(r_lo), 64'd15);

      // Directed vectors, issued back-to-back
      for (int i = 0; i < 10; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 0, r_hi, r_lo);
         check($sformatf("vec%0d_hi", i), 64'(r_hi), 64'(vecs[i].exp_hi));
         check($sformatf("vec%0d_lo", i), 64'(r_lo), 64'(vecs[i].exp_lo));
      end

      // Reset in the middle of a run aborts it without a done pulse
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.op    = 2'b01;
      bus_if.A     = 32'd3;
      bus_if.B     = 32'd3;
      @(posedge clk);
      #1;
      bus_if.start = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("abort_busy", 64'(bus_if.busy), 64'd0);
      check("abort_done", 64'(bus_if.done), 64'd0);
      check("abort_hi", 64'(bus_if.hi), 64'd0);
      check("abort_lo", 64'(bus_if.lo), 64'd0);
      seen_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         seen_done = seen_done | bus_if.done;
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      check("abort_no_done", 64'(seen_done), 64'd0);
      do_op(2'b11, 32'd9, 32'd2, 1'b0, 0, r_hi, r_lo);
      check("after_abort_hi", 64'(r_hi), 64'd1);
      check("after_abort_lo", 64'(r_lo), 64'd4);

      // Random operations against the reference model
      for (int i = 0; i < 150; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 9))
            0: rb = 32'd0;
            1: ra = 32'h8000_0000;
            2: rb = 32'hFFFF_FFFF;
            3: rb = 32'($urandom_range(1, 15));
            default: ;
         endcase
         exp = model(rop, ra, rb);
         do_op(rop, ra, rb, 1'b0, 0, r_hi, r_lo);
         check($sformatf("rand%0d", i), {r_hi, r_lo}, exp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
